ex_wb_stage: RTL and testbench

- Execute-to-writeback pipeline stage of the 16-bit CPU.
- Consumes the ALU/shifter result (SLL/SRL/arith), the destination register and the control bits.
- Buffers them in a 2-entry skid buffer with a valid/ready handshake, selects the writeback data, and drives the register-file write port.
- Provides a combinational forwarding lookup over pending entries so that decode can bypass results that have not yet retired.

---
 rtl/ex_wb_stage.sv | 135 +++++++++++++
 tb/tb_ex_wb_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage of the 16-bit CPU.
//
// This stage takes the ALU/shifter result, the load data and the control bits.
// It picks the writeback data when an entry is captured and holds up to two
// entries in a skid buffer that uses a valid/ready handshake. The oldest entry
// drives the register-file write port. A combinational lookup lets decode take
// results that have not retired yet.
//
// Ports
//   Clock, Reset_n            : rising-edge clock, asynchronous active-low reset
//   InValid/InReady           : upstream handshake (InReady is registered)
//   InResult, InMemData       : ALU/shifter result and load data
//   InMemToReg, InRegWrite    : data select and register-write enable
//   InRd                      : destination register (R0 never written)
//   WbValid/WbReady           : head-entry handshake toward the register file
//   WbEn, WbAddr, WbData      : register-file write port
//   FwdQueryAddr              : source register looked up by decode
//   FwdHit, FwdData           : forwarding result (newest match wins)
//
// Optional (define EX_WB_STATS_EN):
//   StatRetired               : saturating count of pops with WbEn=1
//   StatStall                 : saturating count of cycles with InValid && !InReady
module ex_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [DATA_W-1:0]  InResult,
  input  logic [DATA_W-1:0]  InMemData,
  input  logic               InMemToReg,
  input  logic               InRegWrite,
  input  logic [RADDR_W-1:0] InRd,
  output logic               WbValid,
  input  logic               WbReady,
  output logic               WbEn,
  output logic [RADDR_W-1:0] WbAddr,
  output logic [DATA_W-1:0]  WbData,
  input  logic [RADDR_W-1:0] FwdQueryAddr,
  output logic               FwdHit,
  output logic [DATA_W-1:0]  FwdData
`ifdef EX_WB_STATS_EN
  ,
  output logic [15:0]        StatRetired,
  output logic [15:0]        StatStall
`endif
);

  typedef struct packed {
    logic               en;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nxt;
  entry_t head, tail, in_ent;
  logic   push, pop;
  logic   hit_head, hit_tail;

  // The data mux and the R0 suppression happen at capture, so stored entries
  // are already in their final writeback form.
  assign in_ent = '{en:   InRegWrite && (InRd != '0),
                    rd:   InRd,
                    data: InMemToReg ? InMemData : InResult};

  assign push = InValid && InReady;
  assign pop  = WbValid && WbReady;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= EMPTY;
      InReady <= 1'b1;
      head    <= '0;
      tail    <= '0;
    end else begin
      state   <= state_nxt;
      InReady <= (state_nxt != TWO);
      if (pop) begin
        // The head leaves. The tail moves up, or in ONE a same-cycle push
        // becomes the new head. A pop that empties the buffer leaves head
        // unchanged, so WbAddr/WbData keep their last value.
        if (state == TWO)  head <= tail;
        else if (push)     head <= in_ent;
      end else if (push) begin
        if (state == EMPTY) head <= in_ent;
        else                tail <= in_ent;
      end
    end
  end

  assign WbValid = (state != EMPTY);
  assign WbEn    = WbValid && head.en;
  assign WbAddr  = head.rd;
  assign WbData  = head.data;

  // Only valid entries with en set can match. R0 is never captured with
  // en=1, so a query for R0 never hits. On a double match the tail (newer)
  // entry wins.
  assign hit_tail = (state == TWO) && tail.en && (tail.rd == FwdQueryAddr);
  assign hit_head = WbValid && head.en && (head.rd == FwdQueryAddr);
  assign FwdHit   = hit_tail || hit_head;
  assign FwdData  = hit_tail ? tail.data : (hit_head ? head.data : '0);

`ifdef EX_WB_STATS_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      StatRetired <= '0;
      StatStall   <= '0;
    end else begin
      if (pop && WbEn && (StatRetired != 16'hFFFF))
        StatRetired <= StatRetired + 16'd1;
      if (InValid && !InReady && (StatStall != 16'hFFFF))
        StatStall <= StatStall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage.
// The reference model is an ordered queue of pending writebacks. All expected
// outputs come from the queue contents.
module tb_ex_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        InValid, InReady;
  logic [15:0] InResult, InMemData;
  logic        InMemToReg, InRegWrite;
  logic [1:0]  InRd;
  logic        WbValid, WbReady, WbEn;
  logic [1:0]  WbAddr;
  logic [15:0] WbData;
  logic [1:0]  FwdQueryAddr;
  logic        FwdHit;
  logic [15:0] FwdData;
`ifdef EX_WB_STATS_EN
  logic [15:0] StatRetired, StatStall;
`endif

  ex_wb_stage #(.DATA_W(16), .RADDR_W(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .InValid(InValid), .InReady(InReady),
    .InResult(InResult), .InMemData(InMemData),
    .InMemToReg(InMemToReg), .InRegWrite(InRegWrite), .InRd(InRd),
    .WbValid(WbValid), .WbReady(WbReady), .WbEn(WbEn),
    .WbAddr(WbAddr), .WbData(WbData),
    .FwdQueryAddr(FwdQueryAddr), .FwdHit(FwdHit), .FwdData(FwdData)
`ifdef EX_WB_STATS_EN
    , .StatRetired(StatRetired), .StatStall(StatStall)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        en;
    logic [1:0]  rd;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic [1:0]  last_rd;
  logic [15:0] last_d;
  int          m_ret, m_stall;
  int          n_tot, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        hit;
    logic [15:0] fd;
    chk("in_ready", InReady, q.size() != 2);
    chk("wb_valid", WbValid, q.size() != 0);
    if (q.size() != 0) begin
      chk("wb_en",   WbEn,   q[0].en);
      chk("wb_addr", WbAddr, q[0].rd);
      chk("wb_data", WbData, q[0].d);
      last_rd = q[0].rd;
      last_d  = q[0].d;
    end else begin
      chk("wb_en_empty",   WbEn,   0);
      chk("wb_addr_hold",  WbAddr, last_rd);
      chk("wb_data_hold",  WbData, last_d);
    end
    hit = 1'b0;
    fd  = 16'h0;
    foreach (q[i])
      if (q[i].en && q[i].rd == FwdQueryAddr) begin
        hit = 1'b1;
        fd  = q[i].d;   // later (newer) entries override
      end
    chk("fwd_hit",  FwdHit,  hit);
    chk("fwd_data", FwdData, fd);
`ifdef EX_WB_STATS_EN
    chk("stat_retired", StatRetired, m_ret);
    chk("stat_stall",   StatStall,   m_stall);
`endif
  endtask

  // One clock cycle: drive the inputs, check before the edge, then update the model.
  task automatic step(input logic v, input logic [15:0] res, input logic [15:0] mem,
                      input logic m2r, input logic rw, input logic [1:0] rd,
                      input logic wbr, input logic [1:0] fq);
    logic push, pop;
    ent_t e;
    @(negedge Clock);
    InValid = v; InResult = res; InMemData = mem; InMemToReg = m2r;
    InRegWrite = rw; InRd = rd; WbReady = wbr; FwdQueryAddr = fq;
    #1;
    check_outputs();
    push = v && (q.size() < 2);
    pop  = wbr && (q.size() > 0);
    if (pop && q[0].en && m_ret < 16'hFFFF) m_ret++;
    if (v && q.size() == 2 && m_stall < 16'hFFFF) m_stall++;
    e.en = rw && (rd != 0);
    e.rd = rd;
    e.d  = m2r ? mem : res;
    @(posedge Clock);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
  endtask

  task automatic idle(input logic wbr, input logic [1:0] fq);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0, wbr, fq);
  endtask

  initial begin
    n_tot = 0; n_bad = 0; m_ret = 0; m_stall = 0;
    last_rd = 0; last_d = 0;
    Reset_n = 1'b0;
    InValid = 0; InResult = 0; InMemData = 0; InMemToReg = 0;
    InRegWrite = 0; InRd = 0; WbReady = 0; FwdQueryAddr = 0;
    repeat (2) @(posedge Clock);
    #1;
    check_outputs();                       // reset state
    @(negedge Clock) Reset_n = 1'b1;

    // Basic push, then the entry retires one cycle later.
    step(1, 16'h001E, 16'h0, 0, 1, 2'd1, 1, 2'd1);
    idle(1, 2'd1);
    idle(1, 2'd1);

    // Fill the buffer while stalled. A third push is held off until space opens.
    step(1, 16'h0004, 16'h0, 0, 1, 2'd2, 0, 2'd2);
    step(1, 16'h0008, 16'h0, 0, 1, 2'd3, 0, 2'd3);
    step(1, 16'hFFFF, 16'h0, 0, 1, 2'd1, 0, 2'd1);
    step(1, 16'hFFFF, 16'h0, 0, 1, 2'd1, 1, 2'd1);
    step(1, 16'hFFFF, 16'h0, 0, 1, 2'd1, 1, 2'd1);
    idle(1, 2'd1);
    idle(1, 2'd1);

    // Write to R0 still flows but never writes or forwards.
    step(1, 16'h1234, 16'h0, 0, 1, 2'd0, 0, 2'd0);
    idle(0, 2'd0);
    idle(1, 2'd0);

    // Two pending writes to R2. The newest wins, and the hit ends after the last pop.
    step(1, 16'h0010, 16'h0, 0, 1, 2'd2, 0, 2'd2);
    step(1, 16'h0020, 16'h0, 0, 1, 2'd2, 0, 2'd2);
    idle(1, 2'd2);
    #1 chk("fwd_tail_one_left", FwdData, 16'h0020);
    idle(1, 2'd2);
    idle(0, 2'd2);

    // Load data selected at capture.
    step(1, 16'h0001, 16'hBEEF, 1, 1, 2'd3, 0, 2'd3);
    idle(1, 2'd3);
    idle(1, 2'd3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           1'($urandom), $urandom_range(0, 4) != 0, 2'($urandom),
           $urandom_range(0, 2) != 0, 2'($urandom));

    // Asynchronous reset while the buffer is full.
    idle(0, 2'd1);
    idle(0, 2'd1);
    step(1, 16'hAAAA, 16'h0, 0, 1, 2'd1, 0, 2'd1);
    step(1, 16'h5555, 16'h0, 0, 1, 2'd2, 0, 2'd1);
    while (q.size() < 2) step(1, 16'h7777, 16'h0, 0, 1, 2'd3, 0, 2'd1);
    @(negedge Clock);
    WbReady = 1'b1; InValid = 1'b0;
    FwdQueryAddr = q[1].rd;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_wb_valid", WbValid, 0);
    chk("rst_in_ready", InReady, 1);
    chk("rst_wb_en",    WbEn,    0);
    chk("rst_fwd_hit",  FwdHit,  0);
    chk("rst_fwd_data", FwdData, 0);
`ifdef EX_WB_STATS_EN
    chk("rst_stat_retired", StatRetired, 0);
    chk("rst_stat_stall",   StatStall,   0);
`endif
    q.delete();
    last_rd = 0; last_d = 0; m_ret = 0; m_stall = 0;
    @(posedge Clock);
    #1 chk("rst_no_write", WbEn, 0);
    @(negedge Clock) Reset_n = 1'b1;
    step(1, 16'h0042, 16'h0, 0, 1, 2'd3, 1, 2'd3);
    idle(1, 2'd3);
    idle(1, 2'd3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
